// File: rtl/pocket_event_detector.sv
// Pocket event detector: counts per-frame ball/hole pixel overlap, raises one
// {ball, hole} event per ball per rack, and queues events into a FWFT FIFO.
module pocket_event_detector #(
  parameter int unsigned NUM_BALLS  = 16,
  parameter int unsigned NUM_HOLES  = 6,
  parameter int unsigned MIN_PIXELS = 4,
  parameter int unsigned FIFO_DEPTH = 8,
  localparam int unsigned BW = $clog2(NUM_BALLS),
  localparam int unsigned HW = $clog2(NUM_HOLES),
  localparam int unsigned CW = $clog2(MIN_PIXELS + 1)
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 startOfFrame,
  input  logic [NUM_BALLS-1:0] ballsDR,
  input  logic                 holesDR,
  input  logic [HW-1:0]        holeNumber,
  input  logic                 clearPocketed,
  output logic                 evValid,
  input  logic                 evReady,
  output logic [BW-1:0]        evBall,
  output logic [HW-1:0]        evHole,
  output logic [NUM_BALLS-1:0] pocketedMask,
  output logic                 busy
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned EW = BW + HW;
  localparam logic [CW-1:0] MIN_CNT  = CW'(MIN_PIXELS);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);

  logic [CW-1:0]        pixCnt    [NUM_BALLS];
  logic [CW-1:0]        cntNext   [NUM_BALLS];
  logic [HW-1:0]        holeLatch [NUM_BALLS];
  logic [NUM_BALLS-1:0] ov;
  logic [NUM_BALLS-1:0] trig;
  logic [NUM_BALLS-1:0] pocketed;
  logic [NUM_BALLS-1:0] pending;
  logic [NUM_BALLS-1:0] pendingNext;
  logic [NUM_BALLS-1:0] pushMask;

  logic                 pushReq;
  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 empty;
  logic [BW-1:0]        pushIdx;
  logic [EW-1:0]        pushData;
  logic [EW-1:0]        headNext;

  logic [EW-1:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]        rdPtr;
  logic [AW-1:0]        wrPtr;
  logic [AW-1:0]        rdPtrNext;
  logic [AW:0]          count;
  logic [AW:0]          countNext;

  assign pocketedMask = pocketed;

  // Per-ball overlap, saturating frame pixel count and threshold trigger.
  always_comb begin
    ov   = ballsDR & {NUM_BALLS{holesDR}};
    trig = '0;
    for (int i = 0; i < int'(NUM_BALLS); i++) begin
      cntNext[i] = pixCnt[i];
      if (startOfFrame) begin
        cntNext[i] = ov[i] ? CW'(1) : '0;
      end else if (ov[i] && (pixCnt[i] < MIN_CNT)) begin
        cntNext[i] = pixCnt[i] + CW'(1);
      end
      // A rack clear in the same cycle suppresses any trigger.
      trig[i] = ov[i] & ~pocketed[i] & ~clearPocketed &
                (cntNext[i] == MIN_CNT) & (pixCnt[i] != MIN_CNT);
    end
  end

  // Lowest-index pending arbitration, FIFO push/pop and next head entry.
  always_comb begin
    pushReq  = 1'b0;
    pushIdx  = '0;
    pushMask = '0;
    for (int i = int'(NUM_BALLS) - 1; i >= 0; i--) begin
      if (pending[i]) begin
        pushReq = 1'b1;
        pushIdx = BW'(i);
      end
    end
    full  = (count == FULL_CNT);
    empty = (count == '0);
    pop   = ~empty & evReady;
    // A full FIFO still accepts a push when the head leaves this cycle.
    push  = pushReq & (~full | pop);
    if (push) begin
      pushMask[pushIdx] = 1'b1;
    end
    pushData    = {pushIdx, holeLatch[pushIdx]};
    pendingNext = (pending & ~pushMask) | trig;
    rdPtrNext   = pop ? (rdPtr + AW'(1)) : rdPtr;
    countNext   = count + (AW+1)'(push) - (AW+1)'(pop);
    // Bypass the write when the entry being pushed becomes the new head.
    headNext    = (push && (wrPtr == rdPtrNext)) ? pushData : mem[rdPtrNext];
  end

  // Pixel counters, sticky pocketed flags, pending flags and hole latches.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < int'(NUM_BALLS); i++) begin
        pixCnt[i]    <= '0;
        holeLatch[i] <= '0;
      end
      pocketed <= '0;
      pending  <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_BALLS); i++) begin
        pixCnt[i] <= clearPocketed ? '0 : cntNext[i];
        if (trig[i]) begin
          holeLatch[i] <= holeNumber;
        end
      end
      pocketed <= clearPocketed ? '0 : (pocketed | trig);
      pending  <= pendingNext;
    end
  end

  // Event storage.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wrPtr] <= pushData;
    end
  end

  // FIFO pointers plus registered head, valid and busy outputs.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      rdPtr   <= '0;
      wrPtr   <= '0;
      count   <= '0;
      evValid <= 1'b0;
      evBall  <= '0;
      evHole  <= '0;
      busy    <= 1'b0;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + AW'(1);
      end
      rdPtr   <= rdPtrNext;
      count   <= countNext;
      evValid <= (countNext != '0);
      // Head outputs keep their last value while the FIFO is empty.
      if (countNext != '0) begin
        {evBall, evHole} <= headNext;
      end
      busy <= (|pendingNext) | (countNext != '0);
    end
  end

endmodule
